// File: rtl/dm_arbiter.sv
// ============================================================================
// Module   : dm_arbiter
// Brief    : Two-port round-robin access controller for a synchronous-read word
//            memory, with sub-word read-modify-write and load lane extraction.
//            Optional macro DM_ARB_ALIGN_CHECK_EN enables misalignment errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_arbiter (
    input  logic        arb_clk,
    input  logic        arb_reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_size,
    input  logic        p0_signed,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_size,
    input  logic        p1_signed,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_LRESP = 3'd3,
        S_MERGE = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_owner;
    logic        r_prio;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_any;
    logic        w_pick;
    logic        w_gnt;
    logic        w_sel_we;
    logic [1:0]  w_sel_size;
    logic        w_sel_signed;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_misalign;
    logic        w_done;
    logic        w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    // On a tie r_prio names the winner; a lone requester always wins.
    assign w_any        = p0_req | p1_req;
    assign w_pick       = (p0_req & p1_req) ? r_prio : p1_req;
    assign w_gnt        = (r_state == S_IDLE) & w_any & ~arb_reset;
    assign w_sel_we     = w_pick ? p1_we     : p0_we;
    assign w_sel_size   = w_pick ? p1_size   : p0_size;
    assign w_sel_signed = w_pick ? p1_signed : p0_signed;
    assign w_sel_addr   = w_pick ? p1_addr   : p0_addr;
    assign w_sel_wdata  = w_pick ? p1_wdata  : p0_wdata;

`ifdef DM_ARB_ALIGN_CHECK_EN
    assign w_misalign = ((w_sel_size == 2'b01) & w_sel_addr[0]) |
                        (w_sel_size[1] & (w_sel_addr[1:0] != 2'b00));
    assign w_err      = (r_state == S_ERR);
`else
    assign w_misalign = 1'b0;
    assign w_err      = 1'b0;
`endif

    always_ff @(posedge arb_clk or posedge arb_reset) begin
        if (arb_reset) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_prio   <= 1'b0;
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner  <= w_pick;
                        r_prio   <= ~w_pick;
                        r_we     <= w_sel_we;
                        r_size   <= w_sel_size;
                        r_signed <= w_sel_signed;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                        if (w_misalign)
                            r_state <= S_ERR;
                        else if (w_sel_we && w_sel_size[1])
                            r_state <= S_WRITE;
                        else
                            r_state <= S_READ;
                    end
                end
                S_READ:  r_state <= r_we ? S_MERGE : S_LRESP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // mem_rdata here holds the word addressed during READ.
    always_comb begin
        w_byte  = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_half  = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load  = mem_rdata;
        w_merge = mem_rdata;
        case (r_size)
            2'b00: begin
                w_load = {{24{r_signed & w_byte[7]}}, w_byte};
                w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            end
            2'b01: begin
                w_load = {{16{r_signed & w_half[15]}}, w_half};
                w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            end
            default: begin
                w_load  = mem_rdata;
                w_merge = r_wdata;
            end
        endcase
    end

    assign w_done = (r_state == S_WRITE) | (r_state == S_LRESP) |
                    (r_state == S_MERGE) | (r_state == S_ERR);

    assign p0_gnt   = w_gnt & ~w_pick;
    assign p1_gnt   = w_gnt &  w_pick;
    assign p0_done  = w_done & ~r_owner;
    assign p1_done  = w_done &  r_owner;
    assign p0_err   = w_err & ~r_owner;
    assign p1_err   = w_err &  r_owner;
    assign p0_rdata = ((r_state == S_LRESP) && !r_owner) ? w_load : 32'h0;
    assign p1_rdata = ((r_state == S_LRESP) &&  r_owner) ? w_load : 32'h0;

    assign mem_we    = (r_state == S_WRITE) | (r_state == S_MERGE);
    assign mem_addr  = ((r_state == S_READ) || (r_state == S_LRESP) || mem_we) ?
                       {r_addr[31:2], 2'b00} : 32'h0;
    assign mem_wdata = (r_state == S_WRITE) ? r_wdata :
                       (r_state == S_MERGE) ? w_merge : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// ============================================================================
// Module   : tb_dm_arbiter
// Brief    : Directed self-checking bench for dm_arbiter with a word memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_arbiter;

    logic        arb_clk = 1'b0;
    logic        arb_reset = 1'b0;
    logic        p0_req = 0, p0_we = 0, p0_signed = 0;
    logic [1:0]  p0_size = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0;
    logic        p1_req = 0, p1_we = 0, p1_signed = 0;
    logic [1:0]  p1_size = 0;
    logic [31:0] p1_addr = 0, p1_wdata = 0;
    logic        p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] mem [0:63];
    logic [134:0] outs;

    int total = 0;
    int bad   = 0;

    always #5 arb_clk = ~arb_clk;

    always @(posedge arb_clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:2]];
    end

    assign outs = {p0_gnt, p0_done, p0_rdata, p0_err, p1_gnt, p1_done, p1_rdata,
                   p1_err, mem_we, mem_addr, mem_wdata};

    dm_arbiter dut (
        .arb_clk(arb_clk), .arb_reset(arb_reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_signed(p0_signed),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_signed(p1_signed),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic set_port(input int port, input logic req, input logic we,
                            input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_size = size; p0_signed = sgn;
            p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_size = size; p1_signed = sgn;
            p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    // Runs one access from IDLE; returns observations, leaves the DUT in IDLE.
    task automatic run_access(input int port, input logic we, input logic [1:0] size,
                              input logic sgn, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic ok,
                              output int lat, output logic [31:0] rd, output logic er,
                              output int nwe, output logic [31:0] wa,
                              output logic [31:0] wd);
        logic g, d;
        g = 0; d = 0; lat = 0; rd = 32'hX; er = 1'bX; nwe = 0; wa = 0; wd = 0;
        set_port(port, 1'b1, we, size, sgn, addr, wdata);
        for (int i = 0; i < 8 && !g; i++) begin
            @(negedge arb_clk);
            g = (port == 0) ? p0_gnt : p1_gnt;
        end
        @(posedge arb_clk); #1;
        set_port(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int i = 1; i < 8 && g && !d; i++) begin
            @(negedge arb_clk);
            if (mem_we) begin nwe++; wa = mem_addr; wd = mem_wdata; end
            d = (port == 0) ? p0_done : p1_done;
            if (d) begin
                lat = i;
                rd  = (port == 0) ? p0_rdata : p1_rdata;
                er  = (port == 0) ? p0_err : p1_err;
            end
        end
        @(posedge arb_clk); #1;
        ok = g & d;
    endtask

    task automatic test_reset;
        arb_reset = 1'b1;
        set_port(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        set_port(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(negedge arb_clk);
        total++;
        if (outs !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        set_port(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        @(posedge arb_clk); #1;
        arb_reset = 1'b0;
        @(posedge arb_clk); #1;
        total++;
        if (outs !== '0) begin
            bad++; $display("FAIL idle_outputs: got %h expected 0", outs);
        end
    endtask

    task automatic test_word;
        logic ok, er; int lat, nwe; logic [31:0] rd, wa, wd;
        run_access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, ok, lat, rd, er, nwe, wa, wd);
        total++;
        if (!ok || lat != 1 || nwe != 1 || wa !== 32'h10 || wd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL word_store: ok=%0b lat=%0d nwe=%0d addr=%h data=%h expected 1 1 1 00000010 deadbeef",
                     ok, lat, nwe, wa, wd);
        end
        run_access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, ok, lat, rd, er, nwe, wa, wd);
        total++;
        if (!ok || lat != 2 || nwe != 0 || rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL word_load: ok=%0b lat=%0d nwe=%0d rdata=%h expected 1 2 0 deadbeef",
                     ok, lat, nwe, rd);
        end
    endtask

    task automatic test_subword;
        logic ok, er; int lat, nwe; logic [31:0] rd, wa, wd;
        run_access(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, ok, lat, rd, er, nwe, wa, wd);
        run_access(1, 1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, ok, lat, rd, er, nwe, wa, wd);
        total++;
        if (!ok || lat != 2 || nwe != 1 || wa !== 32'h20 || wd !== 32'h11AA3344 ||
            mem[8] !== 32'h11AA3344) begin
            bad++;
            $display("FAIL sb_merge: ok=%0b lat=%0d nwe=%0d addr=%h data=%h mem=%h expected 1 2 1 00000020 11aa3344",
                     ok, lat, nwe, wa, wd, mem[8]);
        end
        run_access(1, 1'b0, 2'b00, 1'b1, 32'h22, 32'h0, ok, lat, rd, er, nwe, wa, wd);
        total++;
        if (!ok || rd !== 32'hFFFFFFAA) begin
            bad++; $display("FAIL lb_signed: ok=%0b rdata=%h expected ffffffaa", ok, rd);
        end
        run_access(0, 1'b0, 2'b00, 1'b0, 32'h22, 32'h0, ok, lat, rd, er, nwe, wa, wd);
        total++;
        if (!ok || rd !== 32'h000000AA) begin
            bad++; $display("FAIL lbu: ok=%0b rdata=%h expected 000000aa", ok, rd);
        end
        run_access(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, ok, lat, rd, er, nwe, wa, wd);
        total++;
        if (!ok || nwe != 1 || wd !== 32'hBEEF3344) begin
            bad++; $display("FAIL sh_merge: ok=%0b nwe=%0d data=%h expected beef3344", ok, nwe, wd);
        end
        run_access(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h80011234, ok, lat, rd, er, nwe, wa, wd);
        run_access(0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, ok, lat, rd, er, nwe, wa, wd);
        total++;
        if (!ok || lat != 2 || rd !== 32'hFFFF8001) begin
            bad++; $display("FAIL lh_signed: ok=%0b lat=%0d rdata=%h expected ffff8001", ok, lat, rd);
        end
        run_access(1, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, ok, lat, rd, er, nwe, wa, wd);
        total++;
        if (!ok || rd !== 32'h00001234) begin
            bad++; $display("FAIL lhu: ok=%0b rdata=%h expected 00001234", ok, rd);
        end
        run_access(1, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, ok, lat, rd, er, nwe, wa, wd);
        total++;
        if (!ok || rd !== 32'hFFFFFF80) begin
            bad++; $display("FAIL lb_signed_lane3: ok=%0b rdata=%h expected ffffff80", ok, rd);
        end
        run_access(1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, ok, lat, rd, er, nwe, wa, wd);
        total++;
        if (!ok || rd !== 32'h00000012) begin
            bad++; $display("FAIL lb_signed_lane1: ok=%0b rdata=%h expected 00000012", ok, rd);
        end
    endtask

    task automatic test_round_robin;
        int gport[$]; int gcyc[$]; int both, d0, d1, stray;
        both = 0; d0 = 0; d1 = 0; stray = 0;
        arb_reset = 1'b1;
        @(posedge arb_clk); #1;
        arb_reset = 1'b0;
        set_port(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        set_port(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge arb_clk);
            if (p0_gnt && p1_gnt) both++;
            if (p0_gnt) begin gport.push_back(0); gcyc.push_back(i); end
            if (p1_gnt) begin gport.push_back(1); gcyc.push_back(i); end
            if (p0_done) d0++;
            if (p1_done) d1++;
            if (p0_done && p1_done) stray++;
        end
        @(posedge arb_clk); #1;
        set_port(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        total++;
        if (both != 0 || gport.size() != 4) begin
            bad++; $display("FAIL rr_count: both=%0d grants=%0d expected 0 4", both, gport.size());
        end else begin
            total++;
            if (gport[0] != 0 || gport[1] != 1 || gport[2] != 0 || gport[3] != 1 ||
                gcyc[0] != 0 || gcyc[1] != 3 || gcyc[2] != 6 || gcyc[3] != 9) begin
                bad++;
                $display("FAIL rr_order: ports=%0d%0d%0d%0d cycles=%0d,%0d,%0d,%0d expected 0101 0,3,6,9",
                         gport[0], gport[1], gport[2], gport[3], gcyc[0], gcyc[1], gcyc[2], gcyc[3]);
            end
        end
        total++;
        if (d0 != 2 || d1 != 2 || stray != 0) begin
            bad++; $display("FAIL rr_done: p0=%0d p1=%0d both=%0d expected 2 2 0", d0, d1, stray);
        end
    endtask

    task automatic test_reset_merge;
        logic ok, er; int lat, nwe; logic [31:0] rd, wa, wd;
        run_access(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, ok, lat, rd, er, nwe, wa, wd);
        set_port(0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h21, 32'h00000055);
        @(negedge arb_clk);
        total++;
        if (p0_gnt !== 1'b1) begin
            bad++; $display("FAIL rm_gnt: got %b expected 1", p0_gnt);
        end
        @(posedge arb_clk); #1;
        set_port(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        @(posedge arb_clk); #1;
        total++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'h11225544) begin
            bad++; $display("FAIL rm_merge_state: we=%b data=%h expected 1 11225544", mem_we, mem_wdata);
        end
        arb_reset = 1'b1;
        #1;
        total++;
        if (outs !== '0) begin
            bad++; $display("FAIL rm_async_clear: got %h expected 0", outs);
        end
        set_port(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        set_port(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(posedge arb_clk);
        @(negedge arb_clk);
        total++;
        if (mem[8] !== 32'h11223344 || outs !== '0) begin
            bad++; $display("FAIL rm_no_commit: mem=%h outs=%h expected 11223344 0", mem[8], outs);
        end
        @(posedge arb_clk); #1;
        arb_reset = 1'b0;
        @(negedge arb_clk);
        total++;
        if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
            bad++; $display("FAIL rm_tie_after_reset: p0_gnt=%b p1_gnt=%b expected 1 0", p0_gnt, p1_gnt);
        end
        @(posedge arb_clk); #1;
        set_port(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge arb_clk);
        #1;
    endtask

    task automatic test_misalign;
        logic ok, er; int lat, nwe; logic [31:0] rd, wa, wd;
        run_access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h01020304, ok, lat, rd, er, nwe, wa, wd);
        run_access(0, 1'b1, 2'b10, 1'b0, 32'h13, 32'hCAFEF00D, ok, lat, rd, er, nwe, wa, wd);
`ifdef DM_ARB_ALIGN_CHECK_EN
        total++;
        if (!ok || lat != 1 || er !== 1'b1 || nwe != 0 || rd !== 32'h0 || mem[4] !== 32'h01020304) begin
            bad++;
            $display("FAIL misalign_word_err: ok=%0b lat=%0d err=%b nwe=%0d rdata=%h mem=%h expected 1 1 1 0 0 01020304",
                     ok, lat, er, nwe, rd, mem[4]);
        end
        run_access(1, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, ok, lat, rd, er, nwe, wa, wd);
        total++;
        if (!ok || lat != 1 || er !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL misalign_half_err: ok=%0b lat=%0d err=%b rdata=%h expected 1 1 1 0",
                            ok, lat, er, rd);
        end
`else
        total++;
        if (!ok || lat != 1 || er !== 1'b0 || nwe != 1 || wa !== 32'h10 || mem[4] !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL misalign_word_store: ok=%0b lat=%0d err=%b nwe=%0d addr=%h mem=%h expected 1 1 0 1 00000010 cafef00d",
                     ok, lat, er, nwe, wa, mem[4]);
        end
        run_access(1, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, ok, lat, rd, er, nwe, wa, wd);
        total++;
        if (!ok || lat != 2 || er !== 1'b0 || rd !== 32'h0000F00D) begin
            bad++; $display("FAIL misalign_half_load: ok=%0b lat=%0d err=%b rdata=%h expected 1 2 0 0000f00d",
                            ok, lat, er, rd);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_round_robin();
        test_reset_merge();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
